// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scan driver: 12h/24h hours, double-buffered time, digit blink.
// Define DISPLAY_LZB_EN to blank a leading zero on digit 3.
module display_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 250,
  parameter int BLINK_DIV  = 16
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic [4*NUM_DIGITS-1:0] time_bcd,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    mode12,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    am,
  output logic                    pm,
  output logic                    blink_phase,
  output logic                    frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]           presc;
  logic [SW-1:0]           slot;
  logic [FW-1:0]           fcnt;
  logic [4*NUM_DIGITS-1:0] pend_time, disp_time;
  logic [NUM_DIGITS-1:0]   pend_mask, disp_mask;
  logic                    pend_mode, disp_mode, pend_valid;

  logic slot_end, wrap;

  assign slot_end = (presc == PW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (slot == SW'(NUM_DIGITS - 1));

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  // Hour conversion from the committed display copy
  logic [3:0] ht, hu, ht_o, hu_o;
  logic [7:0] hv, hr12, hu_tmp;
  logic       hr_ok, am_n, pm_n;

  always_comb begin
    ht     = disp_time[15:12];
    hu     = disp_time[11:8];
    hr_ok  = ((ht < 4'd2) && (hu <= 4'd9)) ||
             ((ht == 4'd2) && (hu <= 4'd3));
    hv     = {4'd0, ht} * 8'd10 + {4'd0, hu};
    hr12   = hv;
    am_n   = 1'b0;
    pm_n   = 1'b0;
    ht_o   = ht;
    hu_o   = hu;
    hu_tmp = 8'd0;
    if (disp_mode && hr_ok) begin
      if (hv == 8'd0) begin
        hr12 = 8'd12;
        am_n = 1'b1;
      end else if (hv < 8'd12) begin
        am_n = 1'b1;
      end else if (hv == 8'd12) begin
        pm_n = 1'b1;
      end else begin
        hr12 = hv - 8'd12;
        pm_n = 1'b1;
      end
      ht_o   = (hr12 >= 8'd10) ? 4'd1 : 4'd0;
      hu_tmp = hr12 - ((hr12 >= 8'd10) ? 8'd10 : 8'd0);
      hu_o   = hu_tmp[3:0];
    end
  end

  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] sel_n;
  logic [6:0]            seg_n;
  logic                  blink_en, hour_slot;

  always_comb begin
    nib      = 4'd0;
    sel_n    = '0;
    blink_en = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SW'(i)) begin
        sel_n[i] = 1'b1;
        nib      = disp_time[4*i +: 4];
        blink_en = disp_mask[i];
      end
    end
    hour_slot = (slot == SW'(3)) || (slot == SW'(2));
    if (slot == SW'(3)) nib = ht_o;
    if (slot == SW'(2)) nib = hu_o;
    seg_n = seg7(nib);
    if (hour_slot && !hr_ok) seg_n = 7'h40;
`ifdef DISPLAY_LZB_EN
    if ((slot == SW'(3)) && hr_ok && (nib == 4'd0)) seg_n = 7'h00;
`endif
    if (blink_en && blink_phase) seg_n = 7'h00;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      presc       <= '0;
      slot        <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      presc       <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) slot <= wrap ? '0 : slot + SW'(1);
      if (wrap) begin
        if (fcnt == FW'(BLINK_DIV - 1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

  // A load coinciding with a commit becomes the next pending frame
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      pend_time  <= '0;
      pend_mask  <= '0;
      pend_mode  <= 1'b0;
      pend_valid <= 1'b0;
      disp_time  <= '0;
      disp_mask  <= '0;
      disp_mode  <= 1'b0;
    end else begin
      if (wrap && pend_valid) begin
        disp_time <= pend_time;
        disp_mask <= pend_mask;
        disp_mode <= pend_mode;
      end
      if (load) begin
        pend_time  <= time_bcd;
        pend_mask  <= blink_mask;
        pend_mode  <= mode12;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      seg     <= '0;
      dig_sel <= '0;
      am      <= 1'b0;
      pm      <= 1'b0;
    end else begin
      seg     <= seg_n;
      dig_sel <= sel_n;
      am      <= am_n;
      pm      <= pm_n;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver (4 digits, SCAN_DIV=4, BLINK_DIV=2).
// Honours DISPLAY_LZB_EN for the digit-3 zero pattern.
module tb_display_scan_driver;

  logic        Clk, Clr;
  logic [15:0] time_bcd;
  logic [3:0]  blink_mask;
  logic        mode12, load;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        am, pm, blink_phase, frame_start;

`ifdef DISPLAY_LZB_EN
  localparam logic [6:0] Z3 = 7'h00;
`else
  localparam logic [6:0] Z3 = 7'h3F;
`endif

  display_scan_driver #(
    .NUM_DIGITS(4),
    .SCAN_DIV(4),
    .BLINK_DIV(2)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .time_bcd(time_bcd),
    .blink_mask(blink_mask),
    .mode12(mode12),
    .load(load),
    .seg(seg),
    .dig_sel(dig_sel),
    .am(am),
    .pm(pm),
    .blink_phase(blink_phase),
    .frame_start(frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int npass = 0;
  int nframes = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (frame_start) nframes++;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 40);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
    chk("blink_phase", 32'(blink_phase), 32'(nframes[1]));
  endtask

  task automatic do_load(input logic [15:0] t, input logic [3:0] m,
                         input logic md);
    time_bcd   = t;
    blink_mask = m;
    mode12     = md;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [27:0] e,
                             input logic [3:0] m, input logic ea,
                             input logic ep);
    logic [6:0] g [4];
    logic [6:0] x;
    for (int d = 0; d < 4; d++) g[d] = 'x;
    for (int k = 0; k < 15; k++) begin
      tick();
      for (int d = 0; d < 4; d++)
        if (dig_sel == 4'(1 << d)) g[d] = seg;
    end
    for (int d = 0; d < 4; d++) begin
      x = e[7*d +: 7];
      if (m[d] && nframes[1]) x = 7'h00;
      chk($sformatf("%s_dig%0d", tag, d), 32'(g[d]), 32'(x));
    end
    chk({tag, "_am"}, 32'(am), 32'(ea));
    chk({tag, "_pm"}, 32'(pm), 32'(ep));
  endtask

  task automatic show(input string tag, input logic [15:0] t,
                      input logic [3:0] m, input logic md,
                      input logic [27:0] e, input logic ea,
                      input logic ep);
    wait_frame();
    do_load(t, m, md);
    wait_frame();
    check_frame(tag, e, m, ea, ep);
  endtask

  initial begin
    Clr        = 1'b0;
    time_bcd   = '0;
    blink_mask = '0;
    mode12     = 1'b0;
    load       = 1'b0;
    #2;
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dig_sel", 32'(dig_sel), 32'h0);
    repeat (2) tick();
    chk("rst_am", 32'(am), 32'h0);
    chk("rst_pm", 32'(pm), 32'h0);
    chk("rst_blink", 32'(blink_phase), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    Clr     = 1'b1;
    nframes = 0;
    tick();
    chk("first_dig_sel", 32'(dig_sel), 32'h1);
    chk("first_seg", 32'(seg), 32'h3F);

    show("t1_1345_12h", 16'h1345, 4'b0000, 1'b1,
         {Z3, 7'h06, 7'h66, 7'h6D}, 1'b0, 1'b1);
    show("t2_0007_12h", 16'h0007, 4'b0000, 1'b1,
         {7'h06, 7'h5B, 7'h3F, 7'h07}, 1'b1, 1'b0);
    show("t2_0007_24h", 16'h0007, 4'b0000, 1'b0,
         {Z3, 7'h3F, 7'h3F, 7'h07}, 1'b0, 1'b0);

    show("t3_blink", 16'h1345, 4'b0011, 1'b1,
         {Z3, 7'h06, 7'h66, 7'h6D}, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      check_frame($sformatf("t3_blink_f%0d", f),
                  {Z3, 7'h06, 7'h66, 7'h6D}, 4'b0011, 1'b0, 1'b1);
    end

    show("t4_old", 16'h1345, 4'b0000, 1'b1,
         {Z3, 7'h06, 7'h66, 7'h6D}, 1'b0, 1'b1);
    wait_frame();
    repeat (8) tick();
    do_load(16'h0830, 4'b0000, 1'b0);
    do_load(16'h0915, 4'b0000, 1'b0);
    repeat (2) tick();
    chk("t4_mid_dig_sel", 32'(dig_sel), 32'h4);
    chk("t4_mid_seg_old", 32'(seg), 32'h06);
    wait_frame();
    check_frame("t4_new", {Z3, 7'h6F, 7'h06, 7'h6D}, 4'b0000,
                1'b0, 1'b0);

    show("t5_bad", 16'h243A, 4'b0000, 1'b1,
         {7'h40, 7'h40, 7'h4F, 7'h40}, 1'b0, 1'b0);

    show("t6_2345", 16'h2345, 4'b0000, 1'b1,
         {7'h06, 7'h06, 7'h66, 7'h6D}, 1'b0, 1'b1);
    wait_frame();
    repeat (13) tick();
    chk("t6_pre_dig_sel", 32'(dig_sel), 32'h8);
    Clr = 1'b0;
    #2;
    chk("t6_seg", 32'(seg), 32'h0);
    chk("t6_dig_sel", 32'(dig_sel), 32'h0);
    chk("t6_am", 32'(am), 32'h0);
    chk("t6_pm", 32'(pm), 32'h0);
    chk("t6_blink", 32'(blink_phase), 32'h0);
    chk("t6_fs", 32'(frame_start), 32'h0);
    tick();
    Clr     = 1'b1;
    nframes = 0;
    tick();
    chk("t6_rel_dig_sel", 32'(dig_sel), 32'h1);
    chk("t6_rel_seg", 32'(seg), 32'h3F);
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk($sformatf("t6_no_fs_%0d", c), 32'(frame_start), 32'h0);
    end
    tick();
    chk("t6_fs_at_16", 32'(frame_start), 32'h1);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
